// File: rtl/ins_mem_loader.sv
// ins_mem_loader: framed byte-stream loader that writes big-endian 32-bit words into the instruction store
//
// Frame: LEN_HI, LEN_LO (word count N), 4*N data bytes MSB first, optional XOR checksum byte.
// Define LOADER_CHECKSUM_EN to build the CHECK state and the trailing checksum byte.
// Ports:
//   CLK, Reset (async, active-high)
//   Start               one-cycle pulse, honoured in IDLE/DONE/ERROR
//   ByteIn/ByteValid/ByteReady  byte stream handshake
//   InsWE/InsWAddr/InsWData     one-cycle word write strobe, address and data
//   CpuHold, Done, Error        load status
//   WordCount                   words written in the current or last load
module ins_mem_loader #(
  parameter int MEM_BYTES = 128,
  parameter int BASE_ADDR = 0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        InsWE,
  output logic [31:0] InsWAddr,
  output logic [31:0] InsWData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [15:0] WordCount
);
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE, ERROR
  } state_t;
  // State entered once the last word (or an empty frame) has been handled.
  localparam state_t FIN =
`ifdef LOADER_CHECKSUM_EN
    CHECK;
`else
    DONE;
`endif
  localparam logic [31:0] ROOM = 32'(MEM_BYTES - BASE_ADDR);
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, waddr_q, waddr_d, wdata_q, wdata_d;
  logic [23:0] asm_q, asm_d;
  logic [1:0]  idx_q, idx_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  acc_q, acc_d;
`endif
  logic        xfer;
  logic [15:0] n;
  assign xfer = ByteValid & ByteReady;
  assign n    = {len_q[15:8], ByteIn};
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    idx_d   = idx_q;
`ifdef LOADER_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: if (Start) begin
        state_d = LEN_HI;
        cnt_d   = '0;
        idx_d   = '0;
        addr_d  = 32'(BASE_ADDR);
`ifdef LOADER_CHECKSUM_EN
        acc_d   = '0;
`endif
      end
      LEN_HI: if (xfer) begin
        len_d[15:8] = ByteIn;
        state_d     = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        len_d[7:0] = ByteIn;
        state_d    = (n == 16'd0) ? FIN : ({14'd0, n, 2'd0} > ROOM) ? ERROR : DATA;
      end
      DATA: if (xfer) begin
        asm_d = {asm_q[15:0], ByteIn};
        idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        acc_d = acc_q ^ ByteIn;
`endif
        // Latch address/data here so the outputs hold steady outside WRITE.
        if (idx_q == 2'd3) begin
          wdata_d = {asm_q, ByteIn};
          waddr_d = addr_q;
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_q + 16'd1;
        state_d = (cnt_d < len_q) ? DATA : FIN;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (xfer) state_d = (ByteIn == acc_q) ? DONE : ERROR;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
`ifdef LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end
  assign ByteReady = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA)
`ifdef LOADER_CHECKSUM_EN
                     || (state_q == CHECK)
`endif
                     ;
  assign InsWE     = state_q == WRITE;
  assign InsWAddr  = waddr_q;
  assign InsWData  = wdata_q;
  assign CpuHold   = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign Done      = state_q == DONE;
  assign Error     = state_q == ERROR;
  assign WordCount = cnt_q;
endmodule

// File: tb/tb_ins_mem_loader.sv
// tb_ins_mem_loader: randomized frames checked against a frame-level reference model
module tb_ins_mem_loader;
  localparam int MB = 128;
  localparam int BA = 0;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic        CLK = 1'b0;
  logic        Reset, Start, ByteValid;
  logic [7:0]  ByteIn;
  logic        ByteReady, InsWE, CpuHold, Done, Error;
  logic [31:0] InsWAddr, InsWData;
  logic [15:0] WordCount;
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  fb [0:255];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  ins_mem_loader #(.MEM_BYTES(MB), .BASE_ADDR(BA)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .InsWE(InsWE), .InsWAddr(InsWAddr), .InsWData(InsWData),
    .CpuHold(CpuHold), .Done(Done), .Error(Error), .WordCount(WordCount)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge CLK) if (InsWE === 1'b1) begin
    wa_q.push_back(InsWAddr);
    wd_q.push_back(InsWData);
    chk("rdy_in_write", {31'd0, ByteReady}, 32'd0);
  end
  function automatic int gp(input int gm);
    return gm == 0 ? 0 : gm == 1 ? 1 : int'($urandom_range(0, 2));
  endfunction
  task automatic pulse_start;
    @(negedge CLK) Start = 1'b1;
    @(negedge CLK) Start = 1'b0;
  endtask
  task automatic pulse_reset;
    @(negedge CLK) Reset = 1'b1;
    ByteValid = 1'b0;
    Start = 1'b0;
    @(negedge CLK) Reset = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    if (gap > 0) begin
      @(negedge CLK) ByteValid = 1'b0;
      ByteIn = 8'($urandom);
      repeat (gap - 1) @(negedge CLK);
    end
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge CLK);
      ByteValid = 1'b1;
      ByteIn = b;
      ok = ByteReady;
      @(posedge CLK);
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},   {31'd0, ByteReady}, 32'd0);
    chk({tag, "_we"},    {31'd0, InsWE},     32'd0);
    chk({tag, "_hold"},  {31'd0, CpuHold},   32'd0);
    chk({tag, "_done"},  {31'd0, Done},      32'd0);
    chk({tag, "_err"},   {31'd0, Error},     32'd0);
    chk({tag, "_waddr"}, InsWAddr,           32'd0);
    chk({tag, "_wdata"}, InsWData,           32'd0);
    chk({tag, "_wc"},    {16'd0, WordCount}, 32'd0);
  endtask
  // Reference: a frame of n words fits iff 4n <= MB-BA; a fitting frame writes word i at
  // BA+4i as bytes 4i..4i+3 big-endian and ends in DONE unless its checksum byte is wrong.
  task automatic run_frame(input int n, input int gm, input bit bad_in, input bit mid);
    bit fits = (n * 4 <= MB - BA);
    bit bad = bad_in && CK;
    logic [15:0] nn = 16'(n);
    logic [7:0] x = 8'd0;
    int lat = 0;
    int lat_e;
    int nw;
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    chk("hold_start", {31'd0, CpuHold}, 32'd1);
    send(nn[15:8], gp(gm));
    if (mid) begin
      @(negedge CLK) ByteValid = 1'b0;
      Start = 1'b1;
      @(negedge CLK) Start = 1'b0;
    end
    send(nn[7:0], gp(gm));
    if (fits) begin
      for (int i = 0; i < 4 * n; i++) begin
        send(fb[i], gp(gm));
        x ^= fb[i];
      end
      if (CK) send(bad ? x ^ 8'h01 : x, gp(gm));
    end
    while (!(Done || Error) && lat < 30) begin
      @(negedge CLK);
      lat++;
    end
    lat_e = (CK || !fits || n == 0) ? 1 : 2;
    nw = fits ? n : 0;
    chk("latency", lat, lat_e);
    chk("done",  {31'd0, Done},      {31'd0, fits && !bad});
    chk("error", {31'd0, Error},     {31'd0, !fits || bad});
    chk("hold_end", {31'd0, CpuHold}, 32'd0);
    chk("rdy_end", {31'd0, ByteReady}, 32'd0);
    chk("wordcount", {16'd0, WordCount}, nw);
    chk("nwrites", wa_q.size(), nw);
    for (int i = 0; i < nw && i < wa_q.size(); i++) begin
      chk("waddr", wa_q[i], 32'(BA + 4 * i));
      chk("wdata", wd_q[i], {fb[4*i], fb[4*i+1], fb[4*i+2], fb[4*i+3]});
    end
    ByteValid = 1'b0;
    if (lat != lat_e) pulse_reset();
  endtask
  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    ByteValid = 1'b0;
    ByteIn = 8'd0;
    repeat (2) @(negedge CLK);
    chk_reset_vals("reset");
    Reset = 1'b0;
    {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5], fb[6], fb[7]} = 64'h8C010000_AC020004;
    run_frame(2, 0, 1'b0, 1'b0);
    chk("ex_w0", wd_q.size() > 0 ? wd_q[0] : 32'hx, 32'h8C010000);
    chk("ex_w1", wd_q.size() > 1 ? wd_q[1] : 32'hx, 32'hAC020004);
    if (CK) run_frame(2, 0, 1'b1, 1'b0);
    run_frame(2, 1, 1'b0, 1'b0);
    run_frame(33, 0, 1'b0, 1'b0);
    run_frame(32, 0, 1'b0, 1'b0);
    run_frame(0, 0, 1'b0, 1'b1);
    pulse_start();
    send(8'd0, 0);
    send(8'd1, 0);
    send(8'hDE, 0);
    send(8'hAD, 0);
    @(negedge CLK) ByteValid = 1'b0;
    #2 Reset = 1'b1;
    #1 chk_reset_vals("midreset");
    @(negedge CLK) Reset = 1'b0;
    {fb[0], fb[1], fb[2], fb[3]} = 32'h12345678;
    run_frame(1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      int n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(33, 60)) : int'($urandom_range(0, 32));
      for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
      run_frame(n, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
